// File: rtl/bxu_pkg.sv
// Shared constants and buffer entry type for the BXU fetch stage.
package bxu_pkg;
   localparam int ADDR_W          = 16;
   localparam int INSTR_W         = 16;
   localparam int OPCODE_BITWIDTH = 4;
   localparam int OPCODE_LSB      = 0;
   localparam int OPCODE_MSB      = OPCODE_BITWIDTH - 1;
   localparam int OPERAND_LSB     = OPCODE_BITWIDTH;
   localparam int OPERAND_MSB     = INSTR_W - 1;
   localparam int BXU_FETCH_DEPTH = 2;
   localparam int ENTRY_W         = ADDR_W + INSTR_W;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } bxu_entry_t;
endpackage

// File: rtl/bxu_fetch_buf.sv
// 2-entry instruction FIFO with push/pop/flush; flush wins over push and pop.
module bxu_fetch_buf
   import bxu_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push,
   input  logic               pop,
   input  logic               flush,
   input  logic [ENTRY_W-1:0] wdata,
   output logic [1:0]         count,
   output logic [ENTRY_W-1:0] head
);
   bxu_entry_t mem [BXU_FETCH_DEPTH];
   logic       hd;
   logic       tl;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count  <= '0;
         hd     <= 1'b0;
         tl     <= 1'b0;
         mem[0] <= '0;
         mem[1] <= '0;
      end else if (flush) begin
         count <= '0;
         hd    <= 1'b0;
         tl    <= 1'b0;
      end else begin
         if (push) begin
            mem[tl] <= bxu_entry_t'(wdata);
            tl      <= ~tl;
         end
         if (pop) hd <= ~hd;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   assign head = mem[hd];
endmodule

// File: rtl/bxu_fetch.sv
// BXU instruction fetch: PC, end-of-program halt, jump redirect, 2-entry buffer.
// Define BXU_FETCH_LOOP_EN to wrap the PC to 0 at program end instead of halting.
module bxu_fetch
   import bxu_pkg::*;
#(
   parameter int ADDR_BITWIDTH   = ADDR_W,
   parameter int INSTR_BITWIDTH  = INSTR_W,
   parameter int OPCODE_BITWIDTH = bxu_pkg::OPCODE_BITWIDTH,
   parameter int PROG_LEN        = 4
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  en,
   output logic [ADDR_BITWIDTH-1:0]              rom_addr,
   input  logic [INSTR_BITWIDTH-1:0]             rom_data,
   output logic                                  ins_valid,
   input  logic                                  ins_ready,
   output logic [OPCODE_BITWIDTH-1:0]            ins_opcode,
   output logic [INSTR_BITWIDTH-OPCODE_BITWIDTH-1:0] ins_operand,
   output logic [ADDR_BITWIDTH-1:0]              ins_pc,
   input  logic                                  jmp_valid,
   input  logic [ADDR_BITWIDTH-1:0]              jmp_addr,
   output logic                                  halted
);
   logic [ADDR_BITWIDTH-1:0] pc;
   logic [1:0]               count;
   logic                     pop;
   logic                     push;
   logic                     at_end;
   logic                     halt_q;
   bxu_entry_t               wr;
   bxu_entry_t               hd;
   logic [ENTRY_W-1:0]       hd_raw;

   assign pop    = ins_valid & ins_ready;
   assign push   = en & ~halt_q & ~jmp_valid & ((count < 2'(BXU_FETCH_DEPTH)) | pop);
   assign at_end = (pc == ADDR_BITWIDTH'(PROG_LEN - 1));
   assign wr.pc    = pc;
   assign wr.instr = rom_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc     <= '0;
         halt_q <= 1'b0;
      end else if (jmp_valid) begin
         pc     <= jmp_addr;
         halt_q <= 1'b0;
      end else if (push) begin
`ifdef BXU_FETCH_LOOP_EN
         pc <= at_end ? '0 : pc + 1'b1;
`else
         // Halting leaves PC parked on the last address until a redirect.
         if (at_end) halt_q <= 1'b1;
         else        pc     <= pc + 1'b1;
`endif
      end
   end

   bxu_fetch_buf u_buf (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (jmp_valid),
      .wdata (wr),
      .count (count),
      .head  (hd_raw)
   );

   assign hd          = bxu_entry_t'(hd_raw);
   assign rom_addr    = pc;
   assign ins_valid   = (count != 2'd0);
   assign ins_opcode  = hd.instr[OPCODE_BITWIDTH-1:0];
   assign ins_operand = hd.instr[INSTR_BITWIDTH-1:OPCODE_BITWIDTH];
   assign ins_pc      = hd.pc;
`ifdef BXU_FETCH_LOOP_EN
   assign halted = 1'b0;
`else
   assign halted = halt_q;
`endif
endmodule

// File: tb/tb_bxu_fetch.sv
// Self-checking bench for bxu_fetch: directed plan steps then random traffic vs a queue model.
module tb_bxu_fetch;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic [15:0] rom_addr;
   logic [15:0] rom_data;
   logic        ins_valid;
   logic        ins_ready = 1'b0;
   logic [3:0]  ins_opcode;
   logic [11:0] ins_operand;
   logic [15:0] ins_pc;
   logic        jmp_valid = 1'b0;
   logic [15:0] jmp_addr = '0;
   logic        halted;

   int n_assert = 0;
   int n_fail   = 0;

   logic [15:0] rom [4];
   initial begin
      rom[0] = 16'h000B; rom[1] = 16'h2003; rom[2] = 16'h02C3; rom[3] = 16'h0203;
   end
   assign rom_data = rom[rom_addr[1:0]];

   always #5 clk = ~clk;

   bxu_fetch dut (
      .clk(clk), .rst_n(rst_n), .en(en), .rom_addr(rom_addr), .rom_data(rom_data),
      .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_opcode(ins_opcode),
      .ins_operand(ins_operand), .ins_pc(ins_pc), .jmp_valid(jmp_valid),
      .jmp_addr(jmp_addr), .halted(halted)
   );

   // Reference: program order as a queue of {pc, word}, plus next fetch address and halt flag.
   typedef struct { logic [15:0] pc; logic [15:0] w; } ent_t;
   ent_t        q[$];
   logic [15:0] mpc;
   bit          mhalt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      mpc   = '0;
      mhalt = 0;
   endtask

   task automatic model_chk();
      chk("valid", 32'(ins_valid), 32'(q.size() != 0));
      chk("rom_addr", 32'(rom_addr), 32'(mpc));
      chk("halted", 32'(halted), 32'(mhalt));
      if (q.size() != 0) begin
         chk("head_pc", 32'(ins_pc), 32'(q[0].pc));
         chk("head_opcode", 32'(ins_opcode), 32'(q[0].w[3:0]));
         chk("head_operand", 32'(ins_operand), 32'(q[0].w[15:4]));
      end
   endtask

   task automatic model_edge();
      bit   do_pop, do_push;
      ent_t e;
      do_pop = (q.size() != 0) && ins_ready;
      if (jmp_valid) begin
         q.delete();
         mpc   = jmp_addr;
         mhalt = 0;
      end else begin
         do_push = en && !mhalt && (q.size() < 2 || do_pop);
         if (do_pop) void'(q.pop_front());
         if (do_push) begin
            e.pc = mpc;
            e.w  = rom[mpc[1:0]];
            q.push_back(e);
            if (mpc == 16'd3) begin
`ifdef BXU_FETCH_LOOP_EN
               mpc = '0;
`else
               mhalt = 1;
`endif
            end else begin
               mpc = mpc + 16'd1;
            end
         end
      end
   endtask

   // One cycle: drive inputs after negedge, check, take the edge, advance the model.
   task automatic cyc(input bit e, input bit r, input bit jv, input logic [15:0] ja);
      en = e; ins_ready = r; jmp_valid = jv; jmp_addr = ja;
      #1;
      model_chk();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      jmp_valid = 1'b0;
   endtask

   logic [15:0] seen;

   initial begin
      model_reset();
      @(negedge clk);
      chk("rst_valid", 32'(ins_valid), 32'd0);
      chk("rst_opcode", 32'(ins_opcode), 32'd0);
      chk("rst_operand", 32'(ins_operand), 32'd0);
      chk("rst_pc", 32'(ins_pc), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_rom_addr", 32'(rom_addr), 32'd0);
      rst_n = 1'b1;

      // Plan 1 and 4: free-running fetch through end of program.
      cyc(1, 1, 0, 0);
      chk("p1_valid", 32'(ins_valid), 32'd1);
      chk("p1_op0", 32'(ins_opcode), 32'hB);
      chk("p1_opd0", 32'(ins_operand), 32'h000);
      chk("p1_pc0", 32'(ins_pc), 32'd0);
      cyc(1, 1, 0, 0);
      chk("p1_op1", 32'(ins_opcode), 32'h3);
      chk("p1_opd1", 32'(ins_operand), 32'h200);
      chk("p1_pc1", 32'(ins_pc), 32'd1);
      cyc(1, 1, 0, 0);
      chk("p1_opd2", 32'(ins_operand), 32'h02C);
      chk("p1_pc2", 32'(ins_pc), 32'd2);
      cyc(1, 1, 0, 0);
      chk("p1_opd3", 32'(ins_operand), 32'h020);
      chk("p1_pc3", 32'(ins_pc), 32'd3);
      cyc(1, 1, 0, 0);
`ifdef BXU_FETCH_LOOP_EN
      chk("p4_loop_pc0", 32'(ins_pc), 32'd0);
      chk("p4_loop_halted", 32'(halted), 32'd0);
      cyc(1, 1, 0, 0);
      chk("p4_loop_pc1", 32'(ins_pc), 32'd1);
`else
      chk("p4_halted", 32'(halted), 32'd1);
      chk("p4_drained", 32'(ins_valid), 32'd0);
      chk("p4_pc_park", 32'(rom_addr), 32'd3);
      cyc(1, 1, 0, 0);
      chk("p4_still_empty", 32'(ins_valid), 32'd0);
`endif
      cyc(1, 1, 1, 16'd0);
      chk("p4_jmp_unhalt", 32'(halted), 32'd0);
      chk("p4_jmp_empty", 32'(ins_valid), 32'd0);
      chk("p4_jmp_addr", 32'(rom_addr), 32'd0);

      // Plan 2: backpressure fills the buffer and freezes PC.
      for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0);
      chk("p2_pc_hold", 32'(rom_addr), 32'd2);
      chk("p2_head_pc", 32'(ins_pc), 32'd0);
      chk("p2_head_op", 32'(ins_opcode), 32'hB);
      for (int i = 0; i < 4; i++) begin
         seen = ins_pc;
         chk("p2_valid_seq", 32'(ins_valid), 32'd1);
         chk("p2_pc_seq", 32'(seen), 32'(i));
         cyc(1, 1, 0, 0);
      end

      // Plan 3: redirect flushes two buffered entries.
      cyc(1, 1, 1, 16'd0);
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      chk("p3_pre_pc", 32'(ins_pc), 32'd0);
      cyc(1, 0, 1, 16'd2);
      chk("p3_flushed", 32'(ins_valid), 32'd0);
      cyc(1, 0, 0, 0);
      chk("p3_tgt_valid", 32'(ins_valid), 32'd1);
      chk("p3_tgt_pc", 32'(ins_pc), 32'd2);
      chk("p3_tgt_opd", 32'(ins_operand), 32'h02C);

      // Plan 5: fetch disable mid-stream.
      cyc(1, 1, 1, 16'd0);
      cyc(1, 1, 0, 0);
      cyc(1, 1, 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
      chk("p5_frozen", 32'(rom_addr), 32'd2);
      chk("p5_drained", 32'(ins_valid), 32'd0);
      cyc(1, 1, 0, 0);
      chk("p5_resume_pc", 32'(ins_pc), 32'd2);

      // Plan 6: asynchronous reset with a full buffer.
      cyc(1, 1, 1, 16'd0);
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      chk("p6_full_pc", 32'(rom_addr), 32'd2);
      #2 rst_n = 1'b0;
      #1;
      chk("p6_async_valid", 32'(ins_valid), 32'd0);
      chk("p6_async_pc", 32'(rom_addr), 32'd0);
      chk("p6_async_hd", 32'(ins_pc), 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      cyc(1, 1, 0, 0);
      chk("p6_restart_pc", 32'(ins_pc), 32'd0);
      chk("p6_restart_valid", 32'(ins_valid), 32'd1);

      // Random traffic; jump targets beyond the program exercise ROM aliasing.
      for (int i = 0; i < 400; i++)
         cyc(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 9) == 0), 16'($urandom_range(0, 5)));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
